// File: rtl/ddr3_frame_reader_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_frame_reader_pkg
// Shared types and constants for the DDR3 frame reader:
//   - FSM state encoding
//   - Avalon-MM bus widths toward the DDR3 controller
//   - min_burst(): size of the next burst given the words still to fetch
// ----------------------------------------------------------------------------
package ddr3_frame_reader_pkg;

    localparam int AVL_ADDR_W = 26;
    localparam int AVL_DATA_W = 128;
    localparam int AVL_SIZE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CREDIT,
        DRAIN,
        DONE
    } state_t;

    // The last burst of a frame is shortened to whatever is left.
    function automatic logic [31:0] min_burst(input logic [31:0] words_left,
                                              input logic [31:0] burst_len);
        return (words_left < burst_len) ? words_left : burst_len;
    endfunction

endpackage

// File: rtl/ddr3_frame_reader_fifo.sv
// ----------------------------------------------------------------------------
// frame_reader_fifo
// Synchronous first-word-fall-through FIFO, 2**FIFO_PTR_DEPTH entries.
// The head word is visible on dout_o whenever empty_o is low; a push becomes
// visible one cycle later. Push and pop in the same cycle are legal at any
// fill level, including full (the pop frees the slot the push uses).
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   clear_i  synchronous flush (same effect as reset on pointers/count)
//   push_i   write din_i (ignored when full and not popping)
//   pop_i    drop head word (ignored when empty)
//   din_i    write data
//   dout_o   head word
//   empty_o  no words stored
//   full_o   all entries occupied
//   count_o  number of stored words
// ----------------------------------------------------------------------------
module frame_reader_fifo
    import ddr3_frame_reader_pkg::*;
#(
    parameter int FIFO_PTR_DEPTH = 5,
    parameter int DATA_W         = AVL_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_W-1:0]       din_i,
    output logic [DATA_W-1:0]       dout_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [FIFO_PTR_DEPTH:0] count_o
);

    localparam int DEPTH = 2 ** FIFO_PTR_DEPTH;
    localparam logic [FIFO_PTR_DEPTH-1:0] PTR_ONE = FIFO_PTR_DEPTH'(1);

    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [FIFO_PTR_DEPTH-1:0] wr_ptr_q;
    logic [FIFO_PTR_DEPTH-1:0] rd_ptr_q;
    logic [FIFO_PTR_DEPTH:0]   count_q;
    logic                      do_push;
    logic                      do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (FIFO_PTR_DEPTH + 1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !clear_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_q + (FIFO_PTR_DEPTH + 1)'(do_push)
                               - (FIFO_PTR_DEPTH + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/ddr3_frame_reader.sv
// ----------------------------------------------------------------------------
// ddr3_frame_reader
// Avalon-MM burst read master: fetches one frame of FRAME_WORDS 128-bit words
// starting at BASE_ADDR and streams them in order to the pixel path through a
// FWFT FIFO. Requests are throttled by credits (FIFO fill + words in flight)
// so returned data always has a slot.
//
// Ports:
//   sodimm1_ddr3_avl_clk / _reset   clock, synchronous active-high reset
//   frame_start                     pulse: (re)start fetch at BASE_ADDR
//   sodimm1_ddr3_avl_*              read request / return port of controller
//   pix_data / pix_valid / pix_ready  FIFO head toward pixel unpack
//   frame_done                      pulse, cycle after last frame word popped
//   overflow_err                    sticky: return arrived with FIFO full
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | after reset, waiting for the first frame_start
// WAIT_CREDIT | next burst sized, waiting until FIFO can absorb it
// ISSUE       | read_req held until the controller accepts it
// DRAIN       | restart: discard returns of the old frame until none in flight
// DONE        | all bursts of the frame issued, idle until frame_start
// ----------------------------------------------------------------------------
module ddr3_frame_reader
    import ddr3_frame_reader_pkg::*;
#(
    parameter logic [AVL_ADDR_W-1:0] BASE_ADDR      = 26'd0,
    parameter int                    FRAME_WORDS    = 76800,
    parameter int                    BURST_LEN      = 4,
    parameter int                    FIFO_PTR_DEPTH = 5
) (
    input  logic                  sodimm1_ddr3_avl_clk,
    input  logic                  sodimm1_ddr3_avl_reset,
    input  logic                  frame_start,
    input  logic                  sodimm1_ddr3_avl_ready,
    output logic                  sodimm1_ddr3_avl_burstbegin,
    output logic [AVL_ADDR_W-1:0] sodimm1_ddr3_avl_addr,
    output logic                  sodimm1_ddr3_avl_read_req,
    output logic [AVL_SIZE_W-1:0] sodimm1_ddr3_avl_size,
    input  logic                  sodimm1_ddr3_avl_rdata_valid,
    input  logic [AVL_DATA_W-1:0] sodimm1_ddr3_avl_rdata,
    output logic [AVL_DATA_W-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  frame_done,
    output logic                  overflow_err
);

    localparam int FIFO_DEPTH = 2 ** FIFO_PTR_DEPTH;
    localparam int OUT_W      = FIFO_PTR_DEPTH + 1;
    localparam int WL_RAW     = $clog2(FRAME_WORDS + 1);
    localparam int WL_W       = (WL_RAW > AVL_SIZE_W) ? WL_RAW : AVL_SIZE_W + 1;
    localparam logic [WL_W-1:0] LAST_WORD = WL_W'(FRAME_WORDS - 1);

    state_t                  state_q;
    logic [AVL_ADDR_W-1:0]   addr_q;
    logic [WL_W-1:0]         words_left_q;
    logic [WL_W-1:0]         popped_q;
    logic [OUT_W-1:0]        outstanding_q;
    logic [OUT_W-1:0]        outstanding_d;
    logic [AVL_SIZE_W-1:0]   size_q;
    logic [AVL_SIZE_W-1:0]   burst;
    logic                    read_req_q;
    logic                    frame_done_q;
    logic                    overflow_q;

    logic                    fifo_clear;
    logic                    fifo_push;
    logic                    fifo_push_ok;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [FIFO_PTR_DEPTH:0] fifo_count;
    logic [FIFO_PTR_DEPTH:0] fifo_count_d;
    logic                    accept;
    logic                    restart;
    logic                    ret_dec;
    logic [31:0]             credit_need;
    logic                    credit_ok;

    assign sodimm1_ddr3_avl_read_req   = read_req_q;
    assign sodimm1_ddr3_avl_burstbegin = read_req_q;
    assign sodimm1_ddr3_avl_addr       = addr_q;
    assign sodimm1_ddr3_avl_size       = size_q;
    assign frame_done                  = frame_done_q;
    assign overflow_err                = overflow_q;

    assign accept  = read_req_q & sodimm1_ddr3_avl_ready;
    assign restart = frame_start &
                     ((state_q == WAIT_CREDIT) || (state_q == ISSUE) || (state_q == DONE));

    // Returns are only kept while a frame is live; the clear on restart
    // also wins over a same-cycle return.
    assign fifo_clear = restart;
    assign fifo_push  = sodimm1_ddr3_avl_rdata_valid & ~restart &
                        (state_q != IDLE) & (state_q != DRAIN);
    assign pix_valid  = ~fifo_empty & (state_q != DRAIN);
    assign fifo_pop   = pix_valid & pix_ready;

    assign burst = AVL_SIZE_W'(min_burst(32'(words_left_q), 32'(BURST_LEN)));

    // A stray return with nothing in flight must not wrap the credit count.
    assign ret_dec = sodimm1_ddr3_avl_rdata_valid & (outstanding_q != '0);

    // Credit check uses next-cycle FIFO fill and in-flight count, so a pop or
    // return happening this cycle is already credited.
    always_comb begin
        fifo_push_ok  = fifo_push & (~fifo_full | fifo_pop);
        fifo_count_d  = fifo_count + (FIFO_PTR_DEPTH + 1)'(fifo_push_ok)
                                   - (FIFO_PTR_DEPTH + 1)'(fifo_pop);
        outstanding_d = outstanding_q - OUT_W'(ret_dec);
        if (accept) begin
            outstanding_d = outstanding_d + OUT_W'(size_q);
        end
        credit_need   = 32'(fifo_count_d) + 32'(outstanding_d) + 32'(burst);
        credit_ok     = (credit_need <= 32'(FIFO_DEPTH));
    end

    frame_reader_fifo #(
        .FIFO_PTR_DEPTH (FIFO_PTR_DEPTH),
        .DATA_W         (AVL_DATA_W)
    ) u_fifo (
        .clk_i   (sodimm1_ddr3_avl_clk),
        .rst_i   (sodimm1_ddr3_avl_reset),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (sodimm1_ddr3_avl_rdata),
        .dout_o  (pix_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge sodimm1_ddr3_avl_clk) begin
        if (sodimm1_ddr3_avl_reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            words_left_q  <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
            size_q        <= '0;
            read_req_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            frame_done_q  <= fifo_pop & ~restart & (popped_q == LAST_WORD);
            if (fifo_push & fifo_full & ~fifo_pop) begin
                overflow_q <= 1'b1;
            end
            if (fifo_pop) begin
                popped_q <= popped_q + WL_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        addr_q       <= BASE_ADDR;
                        words_left_q <= WL_W'(FRAME_WORDS);
                        popped_q     <= '0;
                        state_q      <= WAIT_CREDIT;
                    end
                end

                WAIT_CREDIT: begin
                    if (frame_start) begin
                        popped_q <= '0;
                        state_q  <= DRAIN;
                    end else if (credit_ok) begin
                        size_q     <= burst;
                        read_req_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (accept) begin
                        read_req_q   <= 1'b0;
                        addr_q       <= addr_q + AVL_ADDR_W'(size_q);
                        words_left_q <= words_left_q - WL_W'(size_q);
                    end
                    if (frame_start) begin
                        read_req_q <= 1'b0;
                        popped_q   <= '0;
                        state_q    <= DRAIN;
                    end else if (accept) begin
                        state_q <= (words_left_q == WL_W'(size_q)) ? DONE : WAIT_CREDIT;
                    end
                end

                DRAIN: begin
                    if (outstanding_q == '0) begin
                        addr_q       <= BASE_ADDR;
                        words_left_q <= WL_W'(FRAME_WORDS);
                        popped_q     <= '0;
                        state_q      <= WAIT_CREDIT;
                    end
                end

                DONE: begin
                    if (frame_start) begin
                        popped_q <= '0;
                        state_q  <= DRAIN;
                    end
                end

                default: begin
                    read_req_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule
